// File: rtl/canal_pkg.sv
// Shared definitions for the canal lock controller: FSM state encoding and side codes.
package canal_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEVEL_IN  = 3'd1,
    ENTER     = 3'd2,
    LEVEL_OUT = 3'd3,
    EXIT      = 3'd4,
    MANUAL    = 3'd5
  } state_t;

  localparam logic SIDE_OUTER = 1'b1;
  localparam logic SIDE_INNER = 1'b0;

endpackage

// File: rtl/gondola_fifo.sv
// Arrival queue of gondola IDs: valid/ready push, pop of the head, occupancy count.
module gondola_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign push_ready = (count != CW'(DEPTH));
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && (count != '0);
  assign head       = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/canal_lock_ctrl.sv
// Two-gate canal lock controller: per-side arrival queues with approach timers,
// automatic transit sequencing and interlocked manual control.
module canal_lock_ctrl #(
  parameter int WATER_W       = 8,
  parameter int OUTER_LEVEL   = 73,
  parameter int INNER_LEVEL   = 49,
  parameter int RESET_LEVEL   = 52,
  parameter int FILL_STEP     = 2,
  parameter int DRAIN_STEP    = 2,
  parameter int ARRIVE_CYCLES = 10,
  parameter int QDEPTH        = 4,
  parameter int ID_W          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        auto_mode,
  input  logic                        fill_req,
  input  logic                        drain_req,
  input  logic                        outer_open_req,
  input  logic                        inner_open_req,
  input  logic                        arrive_valid,
  input  logic                        arrive_side,
  input  logic [ID_W-1:0]             arrive_id,
  output logic                        arrive_ready,
  input  logic                        depart_ack,
  output logic [WATER_W-1:0]          lock_level,
  output logic                        outer_open,
  output logic                        inner_open,
  output logic                        occupied,
  output logic                        occ_dir,
  output logic                        depart_valid,
  output logic [ID_W-1:0]             depart_id,
  output logic [$clog2(QDEPTH+1)-1:0] q_count_outer,
  output logic [$clog2(QDEPTH+1)-1:0] q_count_inner,
  output logic [2:0]                  state
);

  import canal_pkg::*;

  localparam int ACW = (ARRIVE_CYCLES > 0) ? $clog2(ARRIVE_CYCLES+1) : 1;
  localparam logic [WATER_W-1:0] OUT_L = WATER_W'(OUTER_LEVEL);
  localparam logic [WATER_W-1:0] IN_L  = WATER_W'(INNER_LEVEL);
  localparam logic [WATER_W-1:0] RST_L = WATER_W'(RESET_LEVEL);

  state_t             st;
  logic               serve;
  logic               last_served;
  logic [ID_W-1:0]    occ_id;
  logic               rdy_o, rdy_i;
  logic               pop_o, pop_i;
  logic [ID_W-1:0]    head_o, head_i;
  logic [ACW-1:0]     cnt_o, cnt_i;
  logic               elig_o, elig_i;
  logic               man_enter, man_side;
  logic               gates_closed;
  logic [WATER_W-1:0] man_lvl, step_in, step_out, serve_lvl, opp_lvl;
  logic               man_outer, man_inner;

  assign state        = st;
  assign arrive_ready = (arrive_side == SIDE_OUTER) ? rdy_o : rdy_i;

  gondola_fifo #(.DEPTH(QDEPTH), .W(ID_W)) u_fifo_outer (
    .clk        (clk),
    .rst        (rst),
    .push_valid (arrive_valid && (arrive_side == SIDE_OUTER)),
    .push_ready (rdy_o),
    .push_data  (arrive_id),
    .pop        (pop_o),
    .head       (head_o),
    .count      (q_count_outer)
  );

  gondola_fifo #(.DEPTH(QDEPTH), .W(ID_W)) u_fifo_inner (
    .clk        (clk),
    .rst        (rst),
    .push_valid (arrive_valid && (arrive_side == SIDE_INNER)),
    .push_ready (rdy_i),
    .push_data  (arrive_id),
    .pop        (pop_i),
    .head       (head_i),
    .count      (q_count_inner)
  );

  function automatic logic [WATER_W-1:0] fill_lvl(input logic [WATER_W-1:0] lvl);
    logic [WATER_W:0] sum;
    sum = {1'b0, lvl} + (WATER_W+1)'(FILL_STEP);
    return (sum > {1'b0, OUT_L}) ? OUT_L : sum[WATER_W-1:0];
  endfunction

  function automatic logic [WATER_W-1:0] drain_lvl(input logic [WATER_W-1:0] lvl);
    return ({1'b0, lvl} < ({1'b0, IN_L} + (WATER_W+1)'(DRAIN_STEP))) ?
           IN_L : lvl - WATER_W'(DRAIN_STEP);
  endfunction

  function automatic logic [WATER_W-1:0] step_toward(input logic [WATER_W-1:0] lvl,
                                                     input logic [WATER_W-1:0] tgt);
    if (lvl < tgt)      return fill_lvl(lvl);
    else if (lvl > tgt) return drain_lvl(lvl);
    else                return lvl;
  endfunction

  assign elig_o = (q_count_outer != '0) && (cnt_o == ACW'(ARRIVE_CYCLES));
  assign elig_i = (q_count_inner != '0) && (cnt_i == ACW'(ARRIVE_CYCLES));

  // Approach timers restart whenever the head changes (pop) or the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
      cnt_i <= '0;
    end else begin
      if (pop_o || q_count_outer == '0)       cnt_o <= '0;
      else if (cnt_o != ACW'(ARRIVE_CYCLES))  cnt_o <= cnt_o + 1'b1;
      if (pop_i || q_count_inner == '0)       cnt_i <= '0;
      else if (cnt_i != ACW'(ARRIVE_CYCLES))  cnt_i <= cnt_i + 1'b1;
    end
  end

  // Next-level, gate-permission and dequeue decisions for the current cycle.
  always_comb begin
    gates_closed = !outer_open && !inner_open;
    serve_lvl    = (serve == SIDE_OUTER) ? OUT_L : IN_L;
    opp_lvl      = (serve == SIDE_OUTER) ? IN_L : OUT_L;
    step_in      = step_toward(lock_level, serve_lvl);
    step_out     = step_toward(lock_level, opp_lvl);

    man_lvl = lock_level;
    if (gates_closed) begin
      if (fill_req)       man_lvl = fill_lvl(lock_level);
      else if (drain_req) man_lvl = drain_lvl(lock_level);
    end
    // A gate may open only if the level is at its side now and stays there this cycle.
    man_outer = outer_open_req && (lock_level == OUT_L) && (man_lvl == OUT_L) && !inner_open;
    man_inner = inner_open_req && (lock_level == IN_L) && (man_lvl == IN_L) && !outer_open;

    pop_o     = 1'b0;
    pop_i     = 1'b0;
    man_enter = 1'b0;
    man_side  = SIDE_INNER;
    if (st == ENTER) begin
      if (serve == SIDE_OUTER) pop_o = 1'b1;
      else                     pop_i = 1'b1;
    end else if (st == MANUAL && !occupied) begin
      if (outer_open && elig_o) begin
        pop_o     = 1'b1;
        man_enter = 1'b1;
        man_side  = SIDE_OUTER;
      end else if (inner_open && elig_i) begin
        pop_i     = 1'b1;
        man_enter = 1'b1;
        man_side  = SIDE_INNER;
      end
    end
  end

  // Sequencing FSM with registered level, gate and occupancy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      lock_level   <= RST_L;
      outer_open   <= 1'b0;
      inner_open   <= 1'b0;
      occupied     <= 1'b0;
      occ_dir      <= SIDE_INNER;
      occ_id       <= '0;
      depart_valid <= 1'b0;
      depart_id    <= '0;
      serve        <= SIDE_INNER;
      last_served  <= SIDE_INNER;
    end else begin
      depart_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (!auto_mode) begin
            st <= MANUAL;
          end else if (elig_o && elig_i) begin
            serve <= ~last_served;
            st    <= LEVEL_IN;
          end else if (elig_o) begin
            serve <= SIDE_OUTER;
            st    <= LEVEL_IN;
          end else if (elig_i) begin
            serve <= SIDE_INNER;
            st    <= LEVEL_IN;
          end
        end
        LEVEL_IN: begin
          lock_level <= step_in;
          // Transition on the step that lands on target so travel takes ceil(d/step) cycles.
          if (step_in == serve_lvl) begin
            st <= ENTER;
            if (serve == SIDE_OUTER) outer_open <= 1'b1;
            else                     inner_open <= 1'b1;
          end
        end
        ENTER: begin
          outer_open  <= 1'b0;
          inner_open  <= 1'b0;
          occupied    <= 1'b1;
          occ_dir     <= serve;
          occ_id      <= (serve == SIDE_OUTER) ? head_o : head_i;
          last_served <= serve;
          st          <= LEVEL_OUT;
        end
        LEVEL_OUT: begin
          lock_level <= step_out;
          if (step_out == opp_lvl) begin
            st <= EXIT;
            if (serve == SIDE_OUTER) inner_open <= 1'b1;
            else                     outer_open <= 1'b1;
          end
        end
        EXIT: begin
          if (depart_ack) begin
            depart_valid <= 1'b1;
            depart_id    <= occ_id;
            occupied     <= 1'b0;
            outer_open   <= 1'b0;
            inner_open   <= 1'b0;
            st           <= IDLE;
          end
        end
        MANUAL: begin
          lock_level <= man_lvl;
          if (auto_mode && gates_closed && !occupied) begin
            st <= IDLE;
          end else begin
            outer_open <= man_outer;
            inner_open <= man_inner;
          end
          if (man_enter) begin
            occupied <= 1'b1;
            occ_dir  <= man_side;
            occ_id   <= (man_side == SIDE_OUTER) ? head_o : head_i;
          end else if (occupied && depart_ack &&
                       ((occ_dir == SIDE_OUTER) ? inner_open : outer_open)) begin
            depart_valid <= 1'b1;
            depart_id    <= occ_id;
            occupied     <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Directed self-checking bench for canal_lock_ctrl with default parameters.
module tb_canal_lock_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LIN   = 3'd1;
  localparam logic [2:0] S_ENTER = 3'd2;
  localparam logic [2:0] S_LOUT  = 3'd3;
  localparam logic [2:0] S_EXIT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst, auto_mode, fill_req, drain_req, outer_open_req, inner_open_req;
  logic       arrive_valid, arrive_side, arrive_ready, depart_ack;
  logic [3:0] arrive_id, depart_id;
  logic [7:0] lock_level;
  logic       outer_open, inner_open, occupied, occ_dir, depart_valid;
  logic [2:0] q_count_outer, q_count_inner, state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  canal_lock_ctrl dut (
    .clk(clk), .rst(rst), .auto_mode(auto_mode), .fill_req(fill_req), .drain_req(drain_req),
    .outer_open_req(outer_open_req), .inner_open_req(inner_open_req),
    .arrive_valid(arrive_valid), .arrive_side(arrive_side), .arrive_id(arrive_id),
    .arrive_ready(arrive_ready), .depart_ack(depart_ack), .lock_level(lock_level),
    .outer_open(outer_open), .inner_open(inner_open), .occupied(occupied), .occ_dir(occ_dir),
    .depart_valid(depart_valid), .depart_id(depart_id), .q_count_outer(q_count_outer),
    .q_count_inner(q_count_inner), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fill_req = 0; drain_req = 0; outer_open_req = 0; inner_open_req = 0;
    arrive_valid = 0; arrive_side = 0; arrive_id = '0; depart_ack = 0;
  endtask

  task automatic apply_reset(input logic am);
    clear_inputs();
    auto_mode = am;
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int n = 0;
    while (state !== s && n < max) begin tick(); n++; end
    ok = (state === s);
  endtask

  task automatic arrive(input logic side, input logic [3:0] id);
    arrive_valid = 1; arrive_side = side; arrive_id = id;
    tick();
    arrive_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    auto_mode = 1;
    rst = 1;
    tick(); tick();
    checks++; if (lock_level !== 8'd52) begin errors++; $display("FAIL reset_level: got %0d want 52", lock_level); end
    checks++; if (outer_open !== 0 || inner_open !== 0) begin errors++; $display("FAIL reset_gates: got %b%b want 00", outer_open, inner_open); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (q_count_outer !== 0 || q_count_inner !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", q_count_outer, q_count_inner); end
    checks++; if (occupied !== 0 || occ_dir !== 0 || depart_valid !== 0 || depart_id !== 0) begin errors++; $display("FAIL reset_occ: got occ=%b dir=%b dv=%b id=%0d want 0", occupied, occ_dir, depart_valid, depart_id); end
    arrive_side = 1; #1;
    checks++; if (arrive_ready !== 1) begin errors++; $display("FAIL reset_ready_outer: got %b want 1", arrive_ready); end
    arrive_side = 0; #1;
    checks++; if (arrive_ready !== 1) begin errors++; $display("FAIL reset_ready_inner: got %b want 1", arrive_ready); end
    rst = 0;
  endtask

  task automatic test_auto_outer();
    apply_reset(1);
    arrive(1, 4'd5);
    checks++; if (q_count_outer !== 1) begin errors++; $display("FAIL auto_qcount: got %0d want 1", q_count_outer); end
    repeat (10) tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL auto_not_yet_eligible: got %0d want 0", state); end
    tick();
    checks++; if (state !== S_LIN) begin errors++; $display("FAIL auto_level_in: got %0d want 1", state); end
    repeat (10) tick();
    checks++; if (state !== S_LIN || lock_level !== 8'd72) begin errors++; $display("FAIL auto_fill10: got st=%0d lvl=%0d want 1/72", state, lock_level); end
    tick();
    checks++; if (state !== S_ENTER || lock_level !== 8'd73 || outer_open !== 1 || inner_open !== 0) begin errors++; $display("FAIL auto_enter: got st=%0d lvl=%0d g=%b%b want 2/73/10", state, lock_level, outer_open, inner_open); end
    tick();
    checks++; if (state !== S_LOUT || outer_open !== 0 || occupied !== 1 || occ_dir !== 1 || q_count_outer !== 0) begin errors++; $display("FAIL auto_level_out: got st=%0d go=%b occ=%b dir=%b q=%0d want 3/0/1/1/0", state, outer_open, occupied, occ_dir, q_count_outer); end
    repeat (11) tick();
    checks++; if (state !== S_LOUT || lock_level !== 8'd51 || inner_open !== 0) begin errors++; $display("FAIL auto_drain11: got st=%0d lvl=%0d gi=%b want 3/51/0", state, lock_level, inner_open); end
    tick();
    checks++; if (state !== S_EXIT || lock_level !== 8'd49 || inner_open !== 1) begin errors++; $display("FAIL auto_exit: got st=%0d lvl=%0d gi=%b want 4/49/1", state, lock_level, inner_open); end
    repeat (3) tick();
    checks++; if (state !== S_EXIT || inner_open !== 1 || depart_valid !== 0) begin errors++; $display("FAIL auto_exit_hold: got st=%0d gi=%b dv=%b want 4/1/0", state, inner_open, depart_valid); end
    depart_ack = 1;
    tick();
    depart_ack = 0;
    checks++; if (depart_valid !== 1 || depart_id !== 4'd5 || occupied !== 0 || inner_open !== 0 || state !== S_IDLE) begin errors++; $display("FAIL auto_depart: got dv=%b id=%0d occ=%b gi=%b st=%0d want 1/5/0/0/0", depart_valid, depart_id, occupied, inner_open, state); end
    tick();
    checks++; if (depart_valid !== 0) begin errors++; $display("FAIL auto_depart_pulse: got %b want 0", depart_valid); end
  endtask

  task automatic test_queue_full();
    bit ok;
    bit quiet;
    apply_reset(1);
    for (int k = 1; k <= 5; k++) begin
      arrive_valid = 1; arrive_side = 1; arrive_id = 4'(k);
      #1;
      checks++; if (arrive_ready !== (k < 5)) begin errors++; $display("FAIL qfull_ready_%0d: got %b want %b", k, arrive_ready, (k < 5)); end
      tick();
    end
    arrive_valid = 0;
    checks++; if (q_count_outer !== 3'd4) begin errors++; $display("FAIL qfull_count: got %0d want 4", q_count_outer); end
    for (int k = 1; k <= 4; k++) begin
      wait_state(S_EXIT, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL qfull_reach_exit_%0d: got state %0d want 4", k, state); end
      depart_ack = 1;
      tick();
      depart_ack = 0;
      checks++; if (depart_valid !== 1 || depart_id !== 4'(k)) begin errors++; $display("FAIL qfull_depart_%0d: got dv=%b id=%0d want 1/%0d", k, depart_valid, depart_id, k); end
    end
    checks++; if (q_count_outer !== 0) begin errors++; $display("FAIL qfull_drained: got %0d want 0", q_count_outer); end
    quiet = 1;
    repeat (40) begin
      tick();
      if (depart_valid !== 0 || state !== S_IDLE) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL qfull_fifth_dropped: got activity want idle"); end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset(0);
    tick();
    arrive(0, 4'd2);
    arrive(1, 4'd1);
    repeat (12) tick();
    auto_mode = 1;
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rr_back_to_idle: got %0d want 0", state); end
    wait_state(S_EXIT, 60, ok);
    checks++; if (!ok || outer_open !== 0 || inner_open !== 1 || occ_dir !== 1) begin errors++; $display("FAIL rr_first_outer: got st=%0d g=%b%b dir=%b want 4/01/1", state, outer_open, inner_open, occ_dir); end
    depart_ack = 1;
    tick();
    depart_ack = 0;
    checks++; if (depart_valid !== 1 || depart_id !== 4'd1) begin errors++; $display("FAIL rr_depart1: got dv=%b id=%0d want 1/1", depart_valid, depart_id); end
    tick(); tick();
    checks++; if (state !== S_ENTER || inner_open !== 1 || lock_level !== 8'd49) begin errors++; $display("FAIL rr_zero_distance: got st=%0d gi=%b lvl=%0d want 2/1/49", state, inner_open, lock_level); end
    wait_state(S_EXIT, 60, ok);
    checks++; if (!ok || outer_open !== 1 || lock_level !== 8'd73) begin errors++; $display("FAIL rr_second_exit: got st=%0d go=%b lvl=%0d want 4/1/73", state, outer_open, lock_level); end
    depart_ack = 1;
    tick();
    depart_ack = 0;
    checks++; if (depart_valid !== 1 || depart_id !== 4'd2) begin errors++; $display("FAIL rr_depart2: got dv=%b id=%0d want 1/2", depart_valid, depart_id); end
  endtask

  task automatic test_manual();
    int n;
    apply_reset(0);
    inner_open_req = 1;
    tick();
    tick();
    checks++; if (inner_open !== 0 || state !== 3'd5) begin errors++; $display("FAIL man_inner_blocked: got gi=%b st=%0d want 0/5", inner_open, state); end
    drain_req = 1;
    tick();
    checks++; if (lock_level !== 8'd50) begin errors++; $display("FAIL man_drain1: got %0d want 50", lock_level); end
    tick();
    drain_req = 0;
    checks++; if (lock_level !== 8'd49 || inner_open !== 0) begin errors++; $display("FAIL man_drain2: got lvl=%0d gi=%b want 49/0", lock_level, inner_open); end
    tick();
    checks++; if (inner_open !== 1) begin errors++; $display("FAIL man_inner_open: got %b want 1", inner_open); end
    outer_open_req = 1;
    tick();
    checks++; if (outer_open !== 0 || inner_open !== 1) begin errors++; $display("FAIL man_outer_interlock: got %b%b want 01", outer_open, inner_open); end
    fill_req = 1;
    tick();
    checks++; if (lock_level !== 8'd49) begin errors++; $display("FAIL man_fill_gate_open: got %0d want 49", lock_level); end
    fill_req = 0; outer_open_req = 0;
    arrive(0, 4'd9);
    n = 0;
    while (occupied !== 1 && n < 20) begin tick(); n++; end
    checks++; if (occupied !== 1 || occ_dir !== 0 || q_count_inner !== 0) begin errors++; $display("FAIL man_entry: got occ=%b dir=%b q=%0d want 1/0/0", occupied, occ_dir, q_count_inner); end
    inner_open_req = 0;
    tick();
    fill_req = 1;
    repeat (12) tick();
    checks++; if (lock_level !== 8'd73) begin errors++; $display("FAIL man_fill_to_outer: got %0d want 73", lock_level); end
    tick();
    checks++; if (lock_level !== 8'd73) begin errors++; $display("FAIL man_fill_saturate: got %0d want 73", lock_level); end
    fill_req = 0; outer_open_req = 1;
    tick();
    checks++; if (outer_open !== 1) begin errors++; $display("FAIL man_outer_open: got %b want 1", outer_open); end
    depart_ack = 1;
    tick();
    depart_ack = 0;
    checks++; if (depart_valid !== 1 || depart_id !== 4'd9 || occupied !== 0) begin errors++; $display("FAIL man_exit: got dv=%b id=%0d occ=%b want 1/9/0", depart_valid, depart_id, occupied); end
    outer_open_req = 0; auto_mode = 1;
    tick(); tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL man_return_idle: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit quiet;
    apply_reset(1);
    arrive(1, 4'd7);
    arrive(0, 4'd3);
    wait_state(S_LOUT, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_lout: got %0d want 3", state); end
    tick(); tick();
    rst = 1;
    tick();
    checks++; if (lock_level !== 8'd52 || outer_open !== 0 || inner_open !== 0 || state !== S_IDLE) begin errors++; $display("FAIL rstmid_core: got lvl=%0d g=%b%b st=%0d want 52/00/0", lock_level, outer_open, inner_open, state); end
    checks++; if (occupied !== 0 || q_count_outer !== 0 || q_count_inner !== 0 || depart_valid !== 0) begin errors++; $display("FAIL rstmid_clear: got occ=%b q=%0d/%0d dv=%b want 0/0/0/0", occupied, q_count_outer, q_count_inner, depart_valid); end
    rst = 0;
    quiet = 1;
    repeat (30) begin
      tick();
      if (depart_valid !== 0 || state !== S_IDLE) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_depart: got activity want idle"); end
  endtask

  initial begin
    rst = 1;
    auto_mode = 0;
    clear_inputs();
    test_reset();
    test_auto_outer();
    test_queue_full();
    test_round_robin();
    test_manual();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
